// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpu_pkg
// Description : Shared types and constants for the FPU issue/collect path.
// Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    localparam int WORD_W = 32;

    localparam logic [2:0] FOP_FLESS = 3'd0;
    localparam logic [2:0] FOP_FEQ   = 3'd1;
    localparam logic [2:0] FOP_FADD  = 3'd2;
    localparam logic [2:0] FOP_FMUL  = 3'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } dispatch_state_t;

endpackage
`default_nettype wire

// File: rtl/fpu_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : fpu_dispatch
// Description : Single-outstanding issue/collect stage in front of the FPU
//               units. Optional EXEC watchdog: FPU_DISPATCH_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fpu_dispatch
    import fpu_pkg::*;
#(
    parameter int NUM_UNITS = 4,
    parameter int OP_W      = 3,
    parameter int TAG_W     = 5,
    parameter int TIMEOUT   = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [OP_W-1:0]             req_op,
    input  logic [WORD_W-1:0]           req_x1,
    input  logic [WORD_W-1:0]           req_x2,
    input  logic [TAG_W-1:0]            req_tag,
    output logic [WORD_W-1:0]           unit_x1,
    output logic [WORD_W-1:0]           unit_x2,
    output logic [NUM_UNITS-1:0]        unit_start,
    input  logic [WORD_W*NUM_UNITS-1:0] unit_y,
    input  logic [NUM_UNITS-1:0]        unit_idle,
    output logic                        resp_valid,
    input  logic                        resp_ready,
    output logic [WORD_W-1:0]           resp_y,
    output logic [TAG_W-1:0]            resp_tag,
    output logic                        resp_err
);

    localparam int              c_sel_w     = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam logic [OP_W:0]   c_num_units = (OP_W + 1)'(NUM_UNITS);

    dispatch_state_t        r_state;
    dispatch_state_t        w_state_nxt;
    logic [c_sel_w-1:0]     r_sel;
    logic [WORD_W-1:0]      r_x1;
    logic [WORD_W-1:0]      r_x2;
    logic [WORD_W-1:0]      r_y;
    logic [TAG_W-1:0]       r_tag;
    logic                   r_err;
    logic                   w_accept;
    logic                   w_legal;
    logic                   w_capture;
    logic                   w_abort;
    logic                   w_timeout_hit;
    logic [WORD_W-1:0]      w_sel_y;
    logic                   w_sel_idle;

    assign w_legal = ({1'b0, req_op} < c_num_units);

    always_comb begin
        w_sel_y    = '0;
        w_sel_idle = 1'b0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (r_sel == c_sel_w'(i)) begin
                w_sel_y    = unit_y[i*WORD_W +: WORD_W];
                w_sel_idle = unit_idle[i];
            end
        end
    end

    // Start pulse is a pure decode of the START state, so it lasts one cycle.
    always_comb begin
        unit_start = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            unit_start[i] = (r_state == START) && (r_sel == c_sel_w'(i));
        end
    end

`ifdef FPU_DISPATCH_TIMEOUT_EN
    localparam int               c_cnt_w = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
    localparam logic [c_cnt_w-1:0] c_timeout_last = c_cnt_w'(TIMEOUT - 1);

    logic [c_cnt_w-1:0] r_wait_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait_cnt <= '0;
        end else if (r_state == START) begin
            r_wait_cnt <= '0;
        end else if (r_state == WAIT) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // Fires during the TIMEOUT-th consecutive WAIT cycle without idle.
    assign w_timeout_hit = (r_wait_cnt == c_timeout_last);
`else
    logic w_unused_timeout;
    assign w_unused_timeout = (TIMEOUT != 0);
    assign w_timeout_hit    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        w_capture   = 1'b0;
        w_abort     = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
            end
            START: begin
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (w_sel_idle) begin
                    w_capture   = 1'b1;
                    w_state_nxt = DONE;
                end else if (w_timeout_hit) begin
                    w_abort     = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                resp_valid = 1'b1;
                req_ready  = resp_ready;
                if (resp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        // Acceptance overrides the DONE->IDLE hop to allow back-to-back issue.
        w_accept = req_valid && req_ready;
        if (w_accept) begin
            w_state_nxt = w_legal ? START : DONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sel <= '0;
            r_x1  <= '0;
            r_x2  <= '0;
            r_y   <= '0;
            r_tag <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_accept) begin
                r_sel <= req_op[c_sel_w-1:0];
                r_x1  <= req_x1;
                r_x2  <= req_x2;
                r_tag <= req_tag;
                if (!w_legal) begin
                    r_y   <= '0;
                    r_err <= 1'b1;
                end
            end
            if (w_capture) begin
                r_y   <= w_sel_y;
                r_err <= 1'b0;
            end
            if (w_abort) begin
                r_y   <= '0;
                r_err <= 1'b1;
            end
        end
    end

    assign unit_x1  = r_x1;
    assign unit_x2  = r_x2;
    assign resp_y   = r_y;
    assign resp_tag = r_tag;
    assign resp_err = r_err;

endmodule
`default_nettype wire

// File: tb/tb_fpu_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpu_dispatch
// Description : Randomised self-checking bench for fpu_dispatch with
//               behavioural FPU unit models and a transaction-level reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu_dispatch;
    import fpu_pkg::*;

    localparam int NUM_UNITS = 4;
    localparam int OP_W      = 3;
    localparam int TAG_W     = 5;
    localparam int TIMEOUT   = 8;
    localparam int STUCK     = 1000;
`ifdef FPU_DISPATCH_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    req_valid;
    logic                    req_ready;
    logic [OP_W-1:0]         req_op;
    logic [31:0]             req_x1;
    logic [31:0]             req_x2;
    logic [TAG_W-1:0]        req_tag;
    logic [31:0]             unit_x1;
    logic [31:0]             unit_x2;
    logic [NUM_UNITS-1:0]    unit_start;
    logic [32*NUM_UNITS-1:0] unit_y;
    logic [NUM_UNITS-1:0]    unit_idle;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [31:0]             resp_y;
    logic [TAG_W-1:0]        resp_tag;
    logic                    resp_err;

    fpu_dispatch #(
        .NUM_UNITS (NUM_UNITS),
        .OP_W      (OP_W),
        .TAG_W     (TAG_W),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_x1     (req_x1),
        .req_x2     (req_x2),
        .req_tag    (req_tag),
        .unit_x1    (unit_x1),
        .unit_x2    (unit_x2),
        .unit_start (unit_start),
        .unit_y     (unit_y),
        .unit_idle  (unit_idle),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_y     (resp_y),
        .resp_tag   (resp_tag),
        .resp_err   (resp_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- floating-point reference arithmetic ----------------
    function automatic real f2d(input logic [31:0] a);
        logic [10:0] e;
        if (a[30:0] == 31'd0) return $bitstoreal({a[31], 63'd0});
        e = {3'b000, a[30:23]} + 11'd896;
        return $bitstoreal({a[31], e, a[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] d2f(input real r);
        logic [63:0] b;
        logic [10:0] e;
        b = $realtobits(r);
        if (b[62:0] == 63'd0) return {b[63], 31'd0};
        e = b[62:52] - 11'd896;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    function automatic longint fkey(input logic [31:0] a);
        longint m;
        m = longint'({33'd0, a[30:0]});
        return a[31] ? -m : m;
    endfunction

    function automatic logic [31:0] unit_fn(input int u, input logic [31:0] a, input logic [31:0] b);
        case (u)
            0:       return {31'd0, fkey(a) < fkey(b)};
            1:       return {31'd0, fkey(a) == fkey(b)};
            2:       return d2f(f2d(a) + f2d(b));
            default: return d2f(f2d(a) * f2d(b));
        endcase
    endfunction

    function automatic logic [31:0] rand_f();
        return {1'($urandom), 8'($urandom_range(120, 134)), 23'($urandom)};
    endfunction

    // ---------------- unit models: busy for lat[u] cycles after start ----------------
    int                   lat  [NUM_UNITS];
    int                   ucnt [NUM_UNITS];
    int                   act;
    logic [NUM_UNITS-1:0] noise_idle;
    logic [31:0]          noise_y;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_UNITS; i++) ucnt[i] <= 0;
            act        <= 0;
            noise_idle <= '0;
            noise_y    <= '0;
        end else begin
            noise_idle <= NUM_UNITS'($urandom);
            noise_y    <= $urandom;
            for (int i = 0; i < NUM_UNITS; i++) begin
                if (unit_start[i]) begin
                    ucnt[i] <= lat[i];
                    act     <= i;
                end else if (ucnt[i] > 0) begin
                    ucnt[i] <= ucnt[i] - 1;
                end
            end
        end
    end

    always_comb begin
        unit_y    = '0;
        unit_idle = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (i == act) begin
                unit_idle[i]        = (ucnt[i] == 0);
                unit_y[i*32 +: 32]  = unit_fn(i, unit_x1, unit_x2);
            end else begin
                unit_idle[i]        = noise_idle[i];
                unit_y[i*32 +: 32]  = noise_y ^ 32'(i);
            end
        end
    end

    // ---------------- request driver ----------------
    typedef struct {
        logic [OP_W-1:0]  op;
        logic [31:0]      x1;
        logic [31:0]      x2;
        logic [TAG_W-1:0] tag;
    } req_t;

    req_t reqq[$];
    bit   rr_rand = 1'b0;
    logic rr_val  = 1'b1;

    task automatic push(input logic [OP_W-1:0] op, input logic [31:0] x1, input logic [31:0] x2,
                        input logic [TAG_W-1:0] tag);
        req_t r;
        r.op = op; r.x1 = x1; r.x2 = x2; r.tag = tag;
        reqq.push_back(r);
    endtask

    initial begin : driver
        bit hit;
        req_valid  = 1'b0;
        req_op     = '0;
        req_x1     = '0;
        req_x2     = '0;
        req_tag    = '0;
        resp_ready = 1'b1;
        forever begin
            @(negedge clk);
            hit = req_valid && req_ready && !rst;
            @(posedge clk);
            #1;
            if (hit && reqq.size() > 0) void'(reqq.pop_front());
            resp_ready = rr_rand ? 1'($urandom) : rr_val;
            if (reqq.size() > 0) begin
                req_valid = 1'b1;
                req_op    = reqq[0].op;
                req_x1    = reqq[0].x1;
                req_x2    = reqq[0].x2;
                req_tag   = reqq[0].tag;
            end else begin
                req_valid = 1'b0;
            end
        end
    end

    // ---------------- transaction-level reference and monitor ----------------
    bit                   pend = 1'b0;
    bit                   seen = 1'b0;
    int                   due, acc_cyc, meas_lat;
    int                   start_cyc = -1;
    int                   n_acc = 0;
    logic [NUM_UNITS-1:0] start_vec;
    logic [31:0]          ex_y, cur_x1, cur_x2, last_y;
    logic [TAG_W-1:0]     ex_tag;
    logic                 ex_err, last_err;
    int                   acc_log[$];
    int                   vld_log[$];

    initial begin : monitor
        bit ex_rv, ex_rdy;
        cur_x1 = '0;
        cur_x2 = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                pend = 1'b0; seen = 1'b0; start_cyc = -1;
                cur_x1 = '0; cur_x2 = '0;
            end else begin
                ex_rv = pend && (cyc >= due);
                check("resp_valid", 32'(resp_valid), 32'(ex_rv));
                if (ex_rv) begin
                    check("resp_y", resp_y, ex_y);
                    check("resp_tag", 32'(resp_tag), 32'(ex_tag));
                    check("resp_err", 32'(resp_err), 32'(ex_err));
                end
                if (pend && resp_valid && !seen) begin
                    seen     = 1'b1;
                    meas_lat = cyc - acc_cyc;
                    vld_log.push_back(cyc);
                end
                ex_rdy = !pend || (ex_rv && resp_ready);
                check("req_ready", 32'(req_ready), 32'(ex_rdy));
                check("unit_start", 32'(unit_start), (cyc == start_cyc) ? 32'(start_vec) : 32'd0);
                check("unit_x1", unit_x1, cur_x1);
                check("unit_x2", unit_x2, cur_x2);
                if (ex_rv && resp_ready) begin
                    pend     = 1'b0;
                    last_y   = resp_y;
                    last_err = resp_err;
                end
                if (req_valid && ex_rdy) begin
                    acc_cyc = cyc;
                    acc_log.push_back(cyc);
                    n_acc++;
                    cur_x1 = req_x1;
                    cur_x2 = req_x2;
                    ex_tag = req_tag;
                    pend   = 1'b1;
                    seen   = 1'b0;
                    if (int'(req_op) >= NUM_UNITS) begin
                        ex_y = '0; ex_err = 1'b1; due = cyc + 1; start_cyc = -1;
                    end else begin
                        start_cyc = cyc + 1;
                        start_vec = NUM_UNITS'(1) << req_op;
                        if (TO_EN && lat[req_op] >= TIMEOUT) begin
                            ex_y = '0; ex_err = 1'b1; due = cyc + 2 + TIMEOUT;
                        end else begin
                            ex_y = unit_fn(int'(req_op), req_x1, req_x2);
                            ex_err = 1'b0;
                            due = cyc + 3 + lat[req_op];
                        end
                    end
                end
            end
        end
    end

    task automatic drain(input int limit);
        int n = 0;
        while ((reqq.size() > 0 || pend) && n < limit) begin
            @(posedge clk);
            n++;
        end
        check("drain_in_budget", 32'(n < limit), 32'd1);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
        check({tag, "_resp_y"}, resp_y, 32'd0);
        check({tag, "_resp_tag"}, 32'(resp_tag), 32'd0);
        check({tag, "_resp_err"}, 32'(resp_err), 32'd0);
        check({tag, "_unit_start"}, 32'(unit_start), 32'd0);
        check({tag, "_unit_x1"}, unit_x1, 32'd0);
        check({tag, "_unit_x2"}, unit_x2, 32'd0);
    endtask

    initial begin : main
        int n0, w;
        rst = 1'b1;
        for (int i = 0; i < NUM_UNITS; i++) lat[i] = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        rst = 1'b0;

        // combinational fless: 1.0 < 2.0
        push(FOP_FLESS, 32'h3F800000, 32'h40000000, 5'h11);
        drain(100);
        check("t1_latency", 32'(meas_lat), 32'd3);
        check("t1_y", last_y, 32'h00000001);

        // back-to-back: -1.0 < 1.0 then 2.0 < 1.0
        push(FOP_FLESS, 32'hBF800000, 32'h3F800000, 5'h02);
        push(FOP_FLESS, 32'h40000000, 32'h3F800000, 5'h03);
        drain(100);
        check("t2_b2b_same_cycle", 32'(acc_log[$]), 32'(vld_log[$-1]));
        check("t2_second_y", last_y, 32'h00000000);

        // five-cycle fadd: 1.0 + 2.0
        lat[FOP_FADD] = 5;
        push(FOP_FADD, 32'h3F800000, 32'h40000000, 5'h0A);
        drain(100);
        check("t3_latency", 32'(meas_lat), 32'd8);
        check("t3_y", last_y, 32'h40400000);
        lat[FOP_FADD] = 0;

        // writeback stall with a pending second request
        rr_val = 1'b0;
        push(FOP_FEQ, 32'h3F800000, 32'h3F800000, 5'h14);
        push(FOP_FMUL, 32'h40000000, 32'h40000000, 5'h15);
        w = 0;
        while (!resp_valid && w < 50) begin @(posedge clk); w++; end
        n0 = n_acc;
        repeat (4) @(posedge clk);
        #1;
        check("t4_no_accept_while_stalled", 32'(n_acc), 32'(n0));
        check("t4_req_ready_low", 32'(req_ready), 32'd0);
        rr_val = 1'b1;
        drain(100);
        check("t4_fmul_y", last_y, 32'h40800000);

        // illegal op
        push(3'd7, 32'h12345678, 32'h9ABCDEF0, 5'h1F);
        drain(100);
        check("t5_latency", 32'(meas_lat), 32'd1);
        check("t5_err", 32'(last_err), 32'd1);
        check("t5_y", last_y, 32'd0);

        // stuck unit
        lat[FOP_FEQ] = STUCK;
        push(FOP_FEQ, 32'h3F800000, 32'h40000000, 5'h06);
`ifdef FPU_DISPATCH_TIMEOUT_EN
        drain(100);
        check("t6_latency", 32'(meas_lat), 32'(2 + TIMEOUT));
        check("t6_err", 32'(last_err), 32'd1);
        check("t6_y", last_y, 32'd0);
`else
        repeat (100) @(posedge clk);
        #1;
        check("t6_no_resp", 32'(resp_valid), 32'd0);
        check("t6_busy", 32'(req_ready), 32'd0);
        rst = 1'b1;
        #1;
        check_reset_outputs("t6_reset");
        @(negedge clk);
        rst = 1'b0;
`endif
        lat[FOP_FEQ] = 0;

        // asynchronous reset in the middle of WAIT
        lat[FOP_FMUL] = 6;
        n0 = n_acc;
        push(FOP_FMUL, 32'h3FC00000, 32'h40400000, 5'h09);
        w = 0;
        while (n_acc == n0 && w < 50) begin @(negedge clk); w++; end
        check("t7_accepted", 32'(n_acc), 32'(n0 + 1));
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("t7_reset");
        @(negedge clk);
        rst = 1'b0;
        lat[FOP_FMUL] = 0;

        // randomised traffic
        rr_rand = 1'b1;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < NUM_UNITS; i++) lat[i] = $urandom_range(0, 6);
            for (int k = 0; k < 25; k++) begin
                push(OP_W'($urandom_range(0, 9) > 7 ? 0 : $urandom_range(0, 7)),
                     rand_f(), rand_f(), TAG_W'($urandom));
            end
            drain(3000);
        end
        rr_rand = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
